// File: rtl/encode_branch.sv
// RV32I B-type branch encoder with a 2-entry valid/ready output FIFO and a saturating reject counter.
// Optional: define ENCODE_BRANCH_ALIGN_CHECK_EN to reject requests whose offset has bit 0 set.

package instr_type;

    typedef enum logic [2:0] {
        bk_beq     = 3'd0,
        bk_bne     = 3'd1,
        bk_blt     = 3'd2,
        bk_bge     = 3'd3,
        bk_bltu    = 3'd4,
        bk_bgeu    = 3'd5,
        bk_invalid = 3'd6
    } branch_kind_t;

endpackage

module encode_branch
    import instr_type::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  branch_kind_t kind,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [12:0]  offset,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  instr,
    output logic         err,
    output logic [7:0]   err_count
);

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [1:0] FIFO_DEPTH = 2'd2;

    function automatic logic [2:0] funct3_of(input branch_kind_t k);
        logic [2:0] f;
        f = 3'b000;
        case (k)
            bk_beq:  f = 3'b000;
            bk_bne:  f = 3'b001;
            bk_blt:  f = 3'b100;
            bk_bge:  f = 3'b101;
            bk_bltu: f = 3'b110;
            bk_bgeu: f = 3'b111;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        err_q, err_d;
    logic [7:0]  err_count_q, err_count_d;
    logic [31:0] mem_q [2];

    logic        accept;
    logic        misaligned;
    logic        reject;
    logic        push;
    logic        pop;
    logic [31:0] enc_word;

`ifdef ENCODE_BRANCH_ALIGN_CHECK_EN
    assign misaligned = offset[0];
`else
    // Bit 0 of a branch offset is implicitly zero in the encoding; without the check it is dropped.
    logic offset_lsb_unused;
    assign offset_lsb_unused = offset[0];
    assign misaligned        = 1'b0;
`endif

    // Flags only read registered state, so nothing on the input side depends on out_ready.
    assign in_ready  = (count_q != FIFO_DEPTH);
    assign out_valid = (count_q != 2'd0);
    assign instr     = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign err       = err_q;
    assign err_count = err_count_q;

    assign enc_word = {offset[12], offset[10:5], rs2, rs1, funct3_of(kind),
                       offset[4:1], offset[11], OPC_BRANCH};

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        accept      = in_valid && in_ready;
        reject      = accept && ((kind == bk_invalid) || misaligned);
        push        = accept && !reject && !flush;
        pop         = out_valid && out_ready && !flush;

        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        err_d       = reject;
        err_count_d = err_count_q;

        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end

        // Rejections are counted even when flush discards the handshake.
        if (reject && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: storage has no reset; instr is masked to zero while the FIFO is empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_encode_branch.sv
// Directed, table-driven bench for encode_branch: encodings, FIFO ordering/backpressure, errors, flush, reset.

module tb_encode_branch;
    import instr_type::*;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    branch_kind_t kind;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [12:0]  offset;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  instr;
    logic         err;
    logic [7:0]   err_count;

    int n_cmp = 0;
    int n_mis = 0;

    encode_branch dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .kind      (kind),
        .rs1       (rs1),
        .rs2       (rs2),
        .offset    (offset),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .err       (err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        branch_kind_t kind;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [12:0]  off;
        logic [31:0]  exp;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input branch_kind_t k, input logic [4:0] a, input logic [4:0] b,
                         input logic [12:0] o);
        kind   = k;
        rs1    = a;
        rs2    = b;
        offset = o;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(bk_beq, 5'd0, 5'd0, 13'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{bk_beq,  5'd1,  5'd2,  13'd8,    32'h00208463};
        vecs[1] = '{bk_bne,  5'd5,  5'd6,  13'h1FFC, 32'hFE629EE3}; // -4
        vecs[2] = '{bk_bgeu, 5'd0,  5'd31, 13'h1000, 32'h81F07063}; // -4096
        vecs[3] = '{bk_blt,  5'd3,  5'd4,  13'd4094, 32'h7E41CFE3};
        vecs[4] = '{bk_bge,  5'd10, 5'd11, 13'd16,   32'h00B55863};
        vecs[5] = '{bk_bltu, 5'd31, 5'd0,  13'd2048, 32'h000FE0E3};
        vecs[6] = '{bk_beq,  5'd0,  5'd0,  13'h1FFE, 32'hFE000FE3}; // -2

        // Reset values
        do_reset();
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst instr",     instr,          32'h0);
        check("rst err",       32'(err),       32'd0);
        check("rst err_count", 32'(err_count), 32'd0);

        // Streaming: one push and one pop per cycle at count 1
        out_ready = 1'b1;
        drive(vecs[0].kind, vecs[0].rs1, vecs[0].rs2, vecs[0].off);
        in_valid = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            check($sformatf("stream[%0d] out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("stream[%0d] instr", i),     instr,          vecs[i].exp);
            check($sformatf("stream[%0d] in_ready", i),  32'(in_ready),  32'd1);
            if (i + 1 < 7) begin
                drive(vecs[i+1].kind, vecs[i+1].rs1, vecs[i+1].rs2, vecs[i+1].off);
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        check("stream drained", 32'(out_valid), 32'd0);

        // Backpressure: three requests with out_ready low
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[0].kind, vecs[0].rs1, vecs[0].rs2, vecs[0].off);
        step();
        check("bp 1 in_ready", 32'(in_ready), 32'd1);
        drive(vecs[1].kind, vecs[1].rs1, vecs[1].rs2, vecs[1].off);
        step();
        check("bp 2 in_ready", 32'(in_ready), 32'd0);
        check("bp 2 instr",    instr,         vecs[0].exp);
        drive(vecs[2].kind, vecs[2].rs1, vecs[2].rs2, vecs[2].off);
        step();
        check("bp held in_ready", 32'(in_ready), 32'd0);
        check("bp held instr",    instr,         vecs[0].exp);
        out_ready = 1'b1;
        step();
        check("bp pop1 instr",    instr,         vecs[1].exp);
        check("bp pop1 in_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("bp push3 in_ready", 32'(in_ready), 32'd0);
        check("bp push3 instr",    instr,         vecs[1].exp);
        out_ready = 1'b1;
        step();
        check("bp order 3rd", instr, vecs[2].exp);
        step();
        check("bp empty", 32'(out_valid), 32'd0);
        check("bp empty instr", instr, 32'h0);

        // Odd offset
        do_reset();
        drive(bk_beq, 5'd0, 5'd0, 13'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
`ifdef ENCODE_BRANCH_ALIGN_CHECK_EN
        check("odd err",       32'(err),       32'd1);
        check("odd err_count", 32'(err_count), 32'd1);
        check("odd out_valid", 32'(out_valid), 32'd0);
`else
        check("odd err",       32'(err),       32'd0);
        check("odd out_valid", 32'(out_valid), 32'd1);
        check("odd instr",     instr,          32'h00000363);
`endif
        out_ready = 1'b1;
        step();
        check("odd err after", 32'(err),       32'd0);
        check("odd drained",   32'(out_valid), 32'd0);

        // Invalid kind and saturation
        do_reset();
        out_ready = 1'b1;
        drive(bk_invalid, 5'd1, 5'd2, 13'd8);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("inv err",       32'(err),       32'd1);
        check("inv err_count", 32'(err_count), 32'd1);
        check("inv out_valid", 32'(out_valid), 32'd0);
        check("inv in_ready",  32'(in_ready),  32'd1);
        step();
        check("inv err pulse", 32'(err),       32'd0);
        check("inv count hold", 32'(err_count), 32'd1);
        in_valid = 1'b1;
        repeat (253) step();
        check("inv count 254", 32'(err_count), 32'd254);
        repeat (47) step();
        in_valid = 1'b0;
        check("inv sat err", 32'(err), 32'd1);
        step();
        check("inv sat 255",   32'(err_count), 32'd255);
        check("inv sat err0",  32'(err),       32'd0);

        // Flush
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[0].kind, vecs[0].rs1, vecs[0].rs2, vecs[0].off);
        step();
        drive(vecs[1].kind, vecs[1].rs1, vecs[1].rs2, vecs[1].off);
        step();
        check("flush full in_ready", 32'(in_ready), 32'd0);
        flush = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush full out_valid", 32'(out_valid), 32'd0);
        check("flush full in_ready2", 32'(in_ready),  32'd1);
        check("flush full instr",     instr,          32'h0);
        in_valid = 1'b1;
        drive(vecs[0].kind, vecs[0].rs1, vecs[0].rs2, vecs[0].off);
        step();
        out_ready = 1'b1;
        flush     = 1'b1;
        drive(vecs[3].kind, vecs[3].rs1, vecs[3].rs2, vecs[3].off);
        step();
        check("flush push out_valid", 32'(out_valid), 32'd0);
        drive(bk_invalid, 5'd0, 5'd0, 13'd0);
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush rej out_valid", 32'(out_valid), 32'd0);
        check("flush rej err",       32'(err),       32'd1);
        check("flush rej err_count", 32'(err_count), 32'd1);

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(vecs[4].kind, vecs[4].rs1, vecs[4].rs2, vecs[4].off);
        step();
        in_valid = 1'b0;
        check("ares pre out_valid", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check("ares out_valid", 32'(out_valid), 32'd0);
        check("ares in_ready",  32'(in_ready),  32'd1);
        check("ares instr",     instr,          32'h0);
        check("ares err_count", 32'(err_count), 32'd0);
        check("ares err",       32'(err),       32'd0);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        drive(vecs[5].kind, vecs[5].rs1, vecs[5].rs2, vecs[5].off);
        step();
        in_valid = 1'b0;
        check("ares first out_valid", 32'(out_valid), 32'd1);
        check("ares first instr",     instr,          vecs[5].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
